io_supply_sequencer: RTL and testbench

IO_SUPPLY_SEQUENCER -- requirements
Module: io_supply_sequencer

---
 rtl/io_seq_pkg.sv | 21 ++
 rtl/io_sync2.sv | 27 ++
 rtl/io_supply_sequencer.sv | 102 ++++++++++
 tb/tb_io_supply_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_seq_pkg.sv
// Shared types and defaults for the VDDIOX pad-ring power sequencer.
// Imported by the sequencer top and the synchronizer.
package io_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_SETTLE   = 3'd2,
        S_ISO_REL  = 3'd3,
        S_ACTIVE   = 3'd4,
        S_SHUTDOWN = 3'd5,
        S_FAULT    = 3'd6
    } state_e;

    localparam int CNT_W = 8;

    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_SETTLE_CYC   = 64;
    localparam int DEF_ISO_GAP      = 4;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for the raw VDDIOX power-good level.
// Both flops clear to 0 so a reset always looks like "supply not good".
module io_sync2
    import io_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/io_supply_sequencer.sv
// VDDIOX pad-ring sequencer: debounce supply, settle, release isolation,
// then enable drivers; reverse order on shutdown, sticky fault on supply loss.
module io_supply_sequencer
    import io_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int ISO_GAP      = DEF_ISO_GAP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vddiox_ok_i,
    input  logic       req_i,
    input  logic       clear_i,
    output logic       pad_iso_o,
    output logic       pad_oe_en_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(ISO_GAP - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_clr;
    logic             ok_s;

    io_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (vddiox_ok_i),
        .q_o   (ok_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Supply loss outranks a down-request, which outranks timer expiry.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        case (state_q)
            S_OFF: begin
                if (ok_s && req_i) state_d = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                if (!ok_s)                 cnt_clr = 1'b1;
                else if (!req_i)           state_d = S_OFF;
                else if (cnt_q == DEB_LAST) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (!ok_s)                 state_d = S_FAULT;
                else if (!req_i)           state_d = S_OFF;
                else if (cnt_q == SET_LAST) state_d = S_ISO_REL;
            end
            S_ISO_REL: begin
                if (!ok_s)                 state_d = S_FAULT;
                else if (!req_i)           state_d = S_SHUTDOWN;
                else if (cnt_q == GAP_LAST) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!ok_s)       state_d = S_FAULT;
                else if (!req_i) state_d = S_SHUTDOWN;
            end
            S_SHUTDOWN: begin
                if (!ok_s)                 state_d = S_FAULT;
                else if (cnt_q == GAP_LAST) state_d = S_OFF;
            end
            S_FAULT: begin
                if (clear_i) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase

        if (cnt_clr || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign pad_iso_o   = !((state_q == S_ISO_REL) || (state_q == S_ACTIVE));
    assign pad_oe_en_o = (state_q == S_ACTIVE);
    assign ready_o     = (state_q == S_ACTIVE);
    assign fault_o     = (state_q == S_FAULT);
    assign state_o     = state_q;

endmodule

// File: tb/tb_io_supply_sequencer.sv
// Bench for io_supply_sequencer: directed timeline checks plus random
// stimulus against a cycle-level reference model, on two parameter sets.
module tb_io_supply_sequencer;

    localparam int ST_OFF = 0, ST_DEB = 1, ST_SET = 2, ST_ISO = 3;
    localparam int ST_ACT = 4, ST_SHD = 5, ST_FLT = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw = 1'b0;
    logic req = 1'b0;
    logic clr = 1'b0;

    logic       iso0, oe0, rdy0, flt0;
    logic [2:0] st0;
    logic       iso1, oe1, rdy1, flt1;
    logic [2:0] st1;

    int total = 0;
    int bad = 0;

    // reference model state per instance: 0 = defaults, 1 = all ones
    int m_st[2];
    int m_el[2];
    bit m_s1[2];
    bit m_s2[2];
    int m_dur[2][3];

    always #5 clk = ~clk;

    io_supply_sequencer dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .vddiox_ok_i (raw),
        .req_i       (req),
        .clear_i     (clr),
        .pad_iso_o   (iso0),
        .pad_oe_en_o (oe0),
        .ready_o     (rdy0),
        .fault_o     (flt0),
        .state_o     (st0)
    );

    io_supply_sequencer #(
        .DEBOUNCE_CYC (1),
        .SETTLE_CYC   (1),
        .ISO_GAP      (1)
    ) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .vddiox_ok_i (raw),
        .req_i       (req),
        .clear_i     (clr),
        .pad_iso_o   (iso1),
        .pad_oe_en_o (oe1),
        .ready_o     (rdy1),
        .fault_o     (flt1),
        .state_o     (st1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge of the spec's behaviour for instance k.
    task automatic model_edge(input int k);
        int  nxt;
        bit  restart;
        bit  ok;
        int  dur;
        if (!rst_n) begin
            m_st[k] = ST_OFF;
            m_el[k] = 0;
            m_s1[k] = 0;
            m_s2[k] = 0;
            return;
        end
        ok = m_s2[k];
        nxt = m_st[k];
        restart = 0;
        dur = 0;
        case (m_st[k])
            ST_DEB: dur = m_dur[k][0];
            ST_SET: dur = m_dur[k][1];
            ST_ISO, ST_SHD: dur = m_dur[k][2];
            default: dur = 0;
        endcase
        if (m_st[k] == ST_FLT) begin
            if (clr) nxt = ST_OFF;
        end else if (m_st[k] == ST_OFF) begin
            if (ok && req) nxt = ST_DEB;
        end else if (!ok) begin
            if (m_st[k] == ST_DEB) restart = 1;
            else nxt = ST_FLT;
        end else if (!req && m_st[k] != ST_SHD) begin
            nxt = (m_st[k] <= ST_SET) ? ST_OFF : ST_SHD;
        end else if (dur > 0 && m_el[k] + 1 >= dur) begin
            nxt = (m_st[k] == ST_SHD) ? ST_OFF : m_st[k] + 1;
        end
        if (restart || nxt != m_st[k]) m_el[k] = 0;
        else if (m_el[k] < 255) m_el[k]++;
        m_st[k] = nxt;
        m_s2[k] = m_s1[k];
        m_s1[k] = raw;
    endtask

    task automatic compare_all();
        int s;
        for (int k = 0; k < 2; k++) begin
            s = m_st[k];
            if (k == 0) begin
                check("st0", st0, s);
                check("iso0", iso0, (s == ST_ISO || s == ST_ACT) ? 0 : 1);
                check("oe0", oe0, s == ST_ACT);
                check("rdy0", rdy0, s == ST_ACT);
                check("flt0", flt0, s == ST_FLT);
            end else begin
                check("st1", st1, s);
                check("iso1", iso1, (s == ST_ISO || s == ST_ACT) ? 0 : 1);
                check("oe1", oe1, s == ST_ACT);
                check("rdy1", rdy1, s == ST_ACT);
                check("flt1", flt1, s == ST_FLT);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    initial begin : main
        int rdy_e0, iso_e0, rdy_e1, iso_e1;
        m_dur[0][0] = 16; m_dur[0][1] = 64; m_dur[0][2] = 4;
        m_dur[1][0] = 1;  m_dur[1][1] = 1;  m_dur[1][2] = 1;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = ST_OFF; m_el[k] = 0; m_s1[k] = 0; m_s2[k] = 0;
        end

        // reset state, with raw already high and req asserted
        rst_n = 0; raw = 1; req = 1;
        step(); step();
        check("rst_iso", iso0, 1);
        check("rst_rdy", rdy0, 0);
        rst_n = 1; raw = 0;
        step();

        // power-up timeline: raw rises just after edge 0
        raw = 1;
        rdy_e0 = -1; iso_e0 = -1; rdy_e1 = -1; iso_e1 = -1;
        for (int n = 1; n <= 120; n++) begin
            step();
            if (rdy_e0 < 0 && rdy0) rdy_e0 = n;
            if (iso_e0 < 0 && !iso0) iso_e0 = n;
            if (rdy_e1 < 0 && rdy1) rdy_e1 = n;
            if (iso_e1 < 0 && !iso1) iso_e1 = n;
        end
        check("pwrup_rdy_edge", rdy_e0, 87);
        check("pwrup_iso_edge", iso_e0, 83);
        check("min_rdy_edge", rdy_e1, 6);
        check("min_iso_edge", iso_e1, 5);

        // orderly shutdown from ACTIVE
        req = 0;
        step();
        check("shd_oe", oe0, 0);
        check("shd_state", st0, ST_SHD);
        repeat (4) step();
        check("shd_off", st0, ST_OFF);
        check("shd_nofault", flt0, 0);

        // debounce glitch at count 10 restarts the window
        rst_n = 0; raw = 0; req = 1;
        step();
        rst_n = 1;
        step();
        raw = 1;
        rdy_e0 = -1;
        for (int n = 1; n <= 130; n++) begin
            step();
            if (n == 12) raw = 0;
            if (n == 13) raw = 1;
            if (rdy_e0 < 0 && rdy0) rdy_e0 = n;
        end
        check("glitch_rdy_edge", rdy_e0, 99);
        check("glitch_nofault", flt0, 0);

        // supply loss together with req drop
        raw = 0; req = 0;
        step(); step(); step();
        check("loss_state", st0, ST_FLT);
        check("loss_fault", flt0, 1);
        check("loss_iso", iso0, 1);
        req = 1; clr = 1;
        step();
        clr = 0;
        check("clr_off", st0, ST_OFF);
        repeat (5) step();
        check("clr_stay_off", st0, ST_OFF);

        // reset while ACTIVE
        raw = 1;
        repeat (92) step();
        check("pre_rst_rdy", rdy0, 1);
        rst_n = 0;
        step();
        check("rst_act_iso", iso0, 1);
        check("rst_act_oe", oe0, 0);
        check("rst_act_st", st0, ST_OFF);
        rst_n = 1;

        // clear with req and ok high: OFF then DEBOUNCE
        repeat (92) step();
        raw = 0;
        repeat (3) step();
        check("f2_state", st0, ST_FLT);
        raw = 1;
        repeat (4) step();
        clr = 1;
        step();
        clr = 0;
        check("f2_off", st0, ST_OFF);
        step();
        check("f2_deb", st0, ST_DEB);

        // randomized traffic
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 179) == 0) raw = ~raw;
            if ($urandom_range(0, 149) == 0) req = ~req;
            clr = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
